// File: rtl/amp_boot_seq.sv
// rtl/amp_boot_seq.sv - streams an 8-byte boot snapshot to the amplifier over SPI mode 0, MSB first
// Define AMP_BOOT_CSUM_EN to append a ninth byte holding the XOR of bytes 0..7.
module amp_boot_seq #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        amp_init,
  input  logic [63:0] bootmem,
  output logic [7:0]  status,
  output logic        spi_cs_n,
  output logic        spi_sclk,
  output logic        spi_mosi
);

`ifdef AMP_BOOT_CSUM_EN
  localparam logic [3:0] LAST_BYTE = 4'd8;
  localparam int SNAP_W = 64;
  logic [7:0]        csum;
  logic [SNAP_W-1:0] snap_init;

  always_comb begin
    csum = 8'h00;
    for (int i = 0; i < 8; i++) csum = csum ^ bootmem[i*8 +: 8];
  end
  assign snap_init = {csum, bootmem[63:8]};
`else
  localparam logic [3:0] LAST_BYTE = 4'd7;
  localparam int SNAP_W = 56;
  logic [SNAP_W-1:0] snap_init;

  assign snap_init = bootmem[63:8];
`endif

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;
  state_t state, state_d;

  logic              init_q;
  logic              init_valid;
  logic [SNAP_W-1:0] snap;
  logic [7:0]        shreg;
  logic [7:0]        div_cnt;
  logic              sclk_hi;
  logic [2:0]        bit_cnt;
  logic [3:0]        byte_cnt;
  logic              frame_end;
  logic              done;
  logic              overrun;

  logic edge_det;
  logic div_wrap;
  logic accept;
  logic sclk_fall;
  logic finish;

  // init_valid masks the first cycle after reset so a level already high is not seen as an edge
  assign edge_det = amp_init && !init_q && init_valid;
  assign div_wrap = (div_cnt == DIV_LAST);

  always_comb begin
    state_d   = state;
    accept    = 1'b0;
    sclk_fall = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (edge_det) begin
          accept  = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (div_wrap) state_d = SHIFT;
      end
      SHIFT: begin
        if (div_wrap) begin
          if (sclk_hi) sclk_fall = 1'b1;
          else if (frame_end) state_d = HOLD;
        end
      end
      HOLD: begin
        if (div_wrap) begin
          finish  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      init_q     <= 1'b0;
      init_valid <= 1'b0;
      snap       <= '0;
      shreg      <= 8'h00;
      div_cnt    <= 8'h00;
      sclk_hi    <= 1'b0;
      bit_cnt    <= 3'd0;
      byte_cnt   <= 4'd0;
      frame_end  <= 1'b0;
      done       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_d;
      init_q     <= amp_init;
      init_valid <= 1'b1;
      if (accept) begin
        snap      <= snap_init;
        shreg     <= bootmem[7:0];
        div_cnt   <= 8'h00;
        sclk_hi   <= 1'b0;
        bit_cnt   <= 3'd0;
        byte_cnt  <= 4'd0;
        frame_end <= 1'b0;
        done      <= 1'b0;
        overrun   <= 1'b0;
      end else begin
        if (edge_det && state != IDLE) overrun <= 1'b1;
        if (finish) done <= 1'b1;
        if (state != IDLE) div_cnt <= div_wrap ? 8'h00 : div_cnt + 8'h01;
        if (state == SETUP && div_wrap) sclk_hi <= 1'b1;
        if (state == SHIFT && div_wrap) sclk_hi <= !sclk_hi && !frame_end;
        // Data advances on the falling SCLK edge; counters saturate at the last bit of the last byte
        if (sclk_fall) begin
          if (bit_cnt == 3'd7) begin
            if (byte_cnt == LAST_BYTE) begin
              frame_end <= 1'b1;
              shreg     <= {shreg[6:0], 1'b0};
            end else begin
              byte_cnt <= byte_cnt + 4'd1;
              bit_cnt  <= 3'd0;
              shreg    <= snap[7:0];
              snap     <= snap >> 8;
            end
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
            shreg   <= {shreg[6:0], 1'b0};
          end
        end
      end
    end
  end

  assign spi_cs_n = (state == IDLE);
  assign spi_sclk = (state == SHIFT) && sclk_hi;
  assign spi_mosi = (state != IDLE) && shreg[7];
  assign status   = {1'b0, (state == IDLE) ? 4'd0 : byte_cnt, overrun, done, state != IDLE};

endmodule

// File: doc/amp_boot_seq.md
AMP_BOOT_SEQ -- requirements
Module: amp_boot_seq

Interface
REQ-001 Parameter: CLK_DIV, default 2, SPI SCLK half-period in clk cycles (legal 1..255).
REQ-002 Port: clk  in  1  system clock; every flop is rising-edge.
REQ-003 Port: rst_n  in  1  reset, asynchronous assert, active-low; the block has one clock, and reset is asynchronous and active-low.
REQ-004 Port: amp_init  in  1  register-bank "send cfg to amp" bit; a rising edge requests a boot transfer.
REQ-005 Port: bootmem  in  64  boot bytes; bootmem0 in [7:0] through bootmem7 in [63:56].
REQ-006 Port: status  out  8  fed back to the register-bank amp status field.
REQ-007 Port: spi_cs_n  out  1  amplifier chip select, active-low.
REQ-008 Port: spi_sclk  out  1  serial clock, SPI mode 0, idles low.
REQ-009 Port: spi_mosi  out  1  serial data, MSB first.

Function
REQ-010 The block SHALL detect an amp_init rising edge with a registered copy of amp_init; a level held high SHALL NOT retrigger.
REQ-011 FSM states SHALL be IDLE, SETUP, SHIFT, HOLD; DONE is a status flag, not a state.
REQ-012 On an accepted edge in IDLE, the block SHALL latch bootmem into an internal snapshot; later bootmem changes SHALL NOT affect the transfer in progress.
REQ-013 IDLE->SETUP: the cycle after the edge, spi_cs_n goes low and spi_mosi carries byte0 bit7; this lasts CLK_DIV cycles.
REQ-014 SETUP->SHIFT: each bit SHALL have spi_sclk high for CLK_DIV cycles, then low for CLK_DIV cycles.
REQ-015 spi_mosi SHALL change only on the cycle spi_sclk falls, or at SETUP entry.
REQ-016 Bytes SHALL be sent in order byte0..byte7 (plus the checksum byte if enabled), with no gap, and spi_cs_n SHALL stay low for the whole frame.
REQ-017 SHIFT->HOLD after the last bit's falling edge; HOLD lasts CLK_DIV cycles, then spi_cs_n goes high and the FSM returns to IDLE.
REQ-018 spi_cs_n low duration SHALL be exactly 2*CLK_DIV + 16*CLK_DIV*N cycles, where N is the byte count.
REQ-019 status[0] busy SHALL be 1 in every state except IDLE.
REQ-020 status[1] done SHALL set on HOLD->IDLE, stay set (sticky), and clear when the next transfer is accepted.
REQ-021 status[2] overrun SHALL set when an amp_init rising edge occurs while busy; that edge SHALL be ignored.
REQ-022 status[2] SHALL clear when the next transfer is accepted.
REQ-023 status[6:3] SHALL give the index of the byte currently being shifted (0..8), and SHALL be 0 in IDLE.
REQ-024 status[7] SHALL be 0.
REQ-025 The bit counter and byte counter SHALL NOT wrap past their terminal values; the terminal count ends SHIFT.

Reset
REQ-026 While rst_n=0: spi_cs_n=1, spi_sclk=0, spi_mosi=0, status=8'h00, FSM=IDLE, and the edge register=0.
REQ-027 If reset is asserted mid-frame, the frame SHALL be aborted immediately with no partial completion, and done SHALL NOT be set.
REQ-028 If amp_init is already high when reset is released, the block SHALL NOT start a transfer until amp_init goes low and then high again.

Configuration
REQ-029 Macro AMP_BOOT_CSUM_EN SHALL control the checksum byte.
REQ-030 With AMP_BOOT_CSUM_EN defined: N=9, and a ninth byte equal to the XOR of byte0..byte7 SHALL follow byte7.
REQ-031 Without AMP_BOOT_CSUM_EN: N=8, and the checksum logic SHALL be absent.

Verification
REQ-032 Basic frame: CLK_DIV=2, macro off, bootmem=64'h0807060504030201, pulse amp_init -> the MOSI bytes sampled on SCLK rise are 01,02,...,08; cs_n is low for 260 cycles; done=1; busy=0.
REQ-033 Checksum frame: macro on, same bootmem -> a ninth byte 08 follows (XOR of 01..08); cs_n is low for 292 cycles.
REQ-034 Re-trigger while busy: a second amp_init edge 50 cycles into the frame -> the frame is unchanged, status[2]=1, and a later clean edge starts a new frame with status[2]=0.
REQ-035 Snapshot: change bootmem to all-FF mid-frame -> the original bytes are still sent; the next frame sends FF bytes.
REQ-036 Reset mid-frame: drop rst_n at cycle 100 -> cs_n=1, sclk=0, status=00 immediately, with no done; amp_init held high through reset does not start a frame.
REQ-037 CLK_DIV=1 sweep: pattern A5 in every byte -> the SCLK period is 2 cycles, and the MOSI bits read 10100101 per byte.
